led_zone_mean: RTL and testbench
================================

Name: led_zone_mean

Overview:
- Upstream feeder for the LED controller: reduces a raster RGB pixel stream to 8 horizontal zone averages per frame.
- Produces MeanR/MeanG/MeanB (8 x 4-bit each) plus a single-cycle mean_vld pulse.
- mean_vld drives the controller's start input.
- Runs in the clk_slow domain.

Parameters:
- IMG_W, 1024: active pixels per line; power of two, >= 16.
- IMG_H, 512: active lines per frame; power of two, >= 1.
- (derived) ZONE_W = IMG_W/8; ZSH = log2(IMG_W*IMG_H/8); ACC_W = 8+ZSH.

Ports:
- clk_slow  in  1  block clock.
- rst  in  1  reset; synchronous, active-high.
- sof  in  1  start-of-frame pulse, coincident with or before the first pixel.
- pix_vld  in  1  pixel qualifier.
- pix_r  in  8  red sample.
- pix_g  in  8  green sample.
- pix_b  in  8  blue sample.
- MeanR  out  4 x [7:0]  per-zone red mean; index 0 = leftmost zone.
- MeanG  out  4 x [7:0]  per-zone green mean.
- MeanB  out  4 x [7:0]  per-zone blue mean.
- mean_vld  out  1  one-cycle pulse: means updated this cycle.
- frame_err  out  1  one-cycle pulse: frame aborted.

Behaviour:
- Reset, synchronous while rst=1:
  - MeanR/G/B all 0; mean_vld=0; frame_err=0.
  - Accumulators 0; x=0, y=0; state IDLE.
- States:
  - IDLE: pix_vld ignored; sof -> ACCUM.
  - ACCUM: accumulating pixels; last pixel -> LATCH.
  - LATCH: one cycle; means written; -> IDLE.
- sof handling:
  - sof in IDLE: clear all 24 accumulators, x=0, y=0, enter ACCUM.
  - If pix_vld=1 in the same cycle as sof, that pixel is accumulated as pixel (0,0) into freshly cleared accumulators.
- ACCUM, on each pix_vld:
  - zone = x >> log2(ZONE_W).
  - accR[zone] += pix_r, same for G and B; accumulators are ACC_W bits and cannot overflow.
  - x increments; at x=IMG_W-1, x wraps to 0 and y increments.
- Frame end:
  - The pixel at x=IMG_W-1, y=IMG_H-1 is accumulated; next state LATCH.
  - In LATCH (1 cycle after the last pixel), every Mean[z] = acc[z] >> (ZSH+4), i.e. the top 4 bits of the 8-bit mean.
  - mean_vld=1 in that same cycle; then IDLE.
  - Latency from last pixel to mean_vld: 1 cycle.
- Mean outputs hold their values between updates; they are never cleared except by rst.
- sof while in ACCUM (premature frame):
  - frame_err=1 for one cycle.
  - Partial sums discarded; accumulators cleared; restart at (0,0).
  - Means unchanged; no mean_vld.
  - A pixel in the same cycle counts as (0,0) of the new frame.
- sof during LATCH: the latch completes (mean_vld=1), and the new frame starts in that same cycle, exactly as sof in IDLE.
- pix_vld gaps: allowed anywhere, no timeout.
- Pixels after frame end (IDLE, no sof): ignored.
- rst mid-frame: full reset behaviour, no pulses.

Optional Feature:
- Macro: LED_MEAN_ROUND_EN.
- Defined: Mean = min(15, (acc + 2^(ZSH+3)) >> (ZSH+4)), i.e. round-half-up with saturation at 4'hF; an adder of ACC_W+1 bits is required.
- Undefined: plain truncation, Mean = acc >> (ZSH+4).

Test Plan:
- Bench parameters: IMG_W=16, IMG_H=4 (ZONE_W=2, 8 px/zone, ZSH=3).
- Uniform frame: sof, then 64 pixels R=G=B=8'h80 back-to-back -> mean_vld exactly 1 cycle after pixel 63; all Means=4'h8; frame_err=0.
- Zone gradient: zone z pixels = 8'h10*z+8'h05 -> MeanR/G/B[z]=z, z=0..7. Rounding build: also z, because the 0x05 offset is below the rounding half-LSB.
- Rounding/saturation boundary:
  - All pixels 8'h18 -> Means 1 truncated; 2 with LED_MEAN_ROUND_EN.
  - All pixels 8'hFF -> 4'hF in both builds (saturation).
- Abort: sof, 30 pixels, sof, then 64 pixels of 8'h40 -> frame_err pulse at the second sof; single mean_vld at frame end; Means=4'h4; prior Means held until then.
- Gaps / stray pixels / reset:
  - pix_vld toggling 1/0 through a frame -> same result as back-to-back.
  - 10 pix_vld with no sof -> no mean_vld, Means unchanged.
  - rst asserted for 1 cycle mid-frame -> Means=0; next sof+frame completes normally.

Source files
------------

// File: rtl/led_zone_mean.sv
// rtl/led_zone_mean.sv - per-frame 8-zone RGB mean reducer feeding the LED controller (optional rounding: LED_MEAN_ROUND_EN)
module led_zone_mean #(
   parameter int IMG_W = 1024,
   parameter int IMG_H = 512
) (
   input  logic            clk_slow,
   input  logic            rst,
   input  logic            sof,
   input  logic            pix_vld,
   input  logic [7:0]      pix_r,
   input  logic [7:0]      pix_g,
   input  logic [7:0]      pix_b,
   output logic [7:0][3:0] MeanR,
   output logic [7:0][3:0] MeanG,
   output logic [7:0][3:0] MeanB,
   output logic            mean_vld,
   output logic            frame_err
);

   localparam int ZONE_W = IMG_W / 8;
   localparam int ZB     = $clog2(ZONE_W);
   localparam int ZSH    = $clog2(IMG_W * IMG_H / 8);
   localparam int ACC_W  = 8 + ZSH;
   localparam int XW     = $clog2(IMG_W);
   localparam int YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   typedef enum logic [1:0] {IDLE, ACCUM, LATCH} state_t;
   typedef logic [ACC_W-1:0] acc_t;

   state_t        state;
   logic [XW-1:0] x, x_eff;
   logic [YW-1:0] y, y_eff;
   logic [2:0]    zone;
   logic          take, last;
   acc_t          acc_r [8], acc_g [8], acc_b [8];
   acc_t          nxt_r [8], nxt_g [8], nxt_b [8];

   // 4-bit zone mean from a zone sum (8-bit mean's top nibble)
`ifdef LED_MEAN_ROUND_EN
   function automatic logic [3:0] to_mean(input acc_t a);
      logic [ACC_W:0] s;
      s = {1'b0, a} + (ACC_W + 1)'(2 ** (ZSH + 3));
      return s[ACC_W] ? 4'hF : s[ACC_W-1 -: 4];
   endfunction
`else
   function automatic logic [3:0] to_mean(input acc_t a);
      return a[ACC_W-1 -: 4];
   endfunction
`endif

   // Next accumulator values; sof restarts the frame at (0,0) with cleared sums,
   // and the forwarded sums let the means be registered alongside the last pixel
   always_comb begin
      x_eff = sof ? '0 : x;
      y_eff = sof ? '0 : y;
      zone  = 3'(x_eff >> ZB);
      take  = pix_vld && (sof || state == ACCUM);
      last  = take && (x_eff == XW'(IMG_W - 1)) && (y_eff == YW'(IMG_H - 1));
      for (int z = 0; z < 8; z++) begin
         nxt_r[z] = sof ? '0 : acc_r[z];
         nxt_g[z] = sof ? '0 : acc_g[z];
         nxt_b[z] = sof ? '0 : acc_b[z];
         if (take && zone == 3'(z)) begin
            nxt_r[z] = nxt_r[z] + ACC_W'(pix_r);
            nxt_g[z] = nxt_g[z] + ACC_W'(pix_g);
            nxt_b[z] = nxt_b[z] + ACC_W'(pix_b);
         end
      end
   end

   // Frame FSM, raster position, accumulators and registered outputs
   always_ff @(posedge clk_slow) begin
      if (rst) begin
         state     <= IDLE;
         x         <= '0;
         y         <= '0;
         mean_vld  <= 1'b0;
         frame_err <= 1'b0;
         MeanR     <= '0;
         MeanG     <= '0;
         MeanB     <= '0;
         for (int z = 0; z < 8; z++) begin
            acc_r[z] <= '0;
            acc_g[z] <= '0;
            acc_b[z] <= '0;
         end
      end else begin
         for (int z = 0; z < 8; z++) begin
            acc_r[z] <= nxt_r[z];
            acc_g[z] <= nxt_g[z];
            acc_b[z] <= nxt_b[z];
         end
         mean_vld  <= last;
         frame_err <= sof && (state == ACCUM);
         if (last) begin
            for (int z = 0; z < 8; z++) begin
               MeanR[z] <= to_mean(nxt_r[z]);
               MeanG[z] <= to_mean(nxt_g[z]);
               MeanB[z] <= to_mean(nxt_b[z]);
            end
         end
         if (take) begin
            x <= x_eff + XW'(1);
            y <= (x_eff == XW'(IMG_W - 1)) ? y_eff + YW'(1) : y_eff;
         end else if (sof) begin
            x <= '0;
            y <= '0;
         end
         if (last)
            state <= LATCH;
         else if (sof)
            state <= ACCUM;
         else if (state == LATCH)
            state <= IDLE;
      end
   end

endmodule

// File: tb/tb_led_zone_mean.sv
// tb/tb_led_zone_mean.sv - scoreboard bench for led_zone_mean at 16x4
module tb_led_zone_mean;

   logic            clk_slow, rst, sof, pix_vld;
   logic [7:0]      pix_r, pix_g, pix_b;
   logic [7:0][3:0] MeanR, MeanG, MeanB;
   logic            mean_vld, frame_err;

   led_zone_mean #(.IMG_W(16), .IMG_H(4)) dut (
      .clk_slow(clk_slow), .rst(rst), .sof(sof), .pix_vld(pix_vld),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .MeanR(MeanR), .MeanG(MeanG), .MeanB(MeanB),
      .mean_vld(mean_vld), .frame_err(frame_err)
   );

   typedef struct {
      int          cyc;
      logic [31:0] r, g, b;
   } exp_t;

   exp_t        exp_q[$];
   int          err_q[$];
   int          cyc = 0;
   int          n_tests = 0, n_fail = 0;
   int          sr[8], sg[8], sb[8];
   int          mx, my;
   bit          m_acc;
   logic [31:0] last_r, last_g, last_b;
   exp_t        mon_e;
   int          mon_c;

   initial begin
      clk_slow = 0;
      forever #5 clk_slow = ~clk_slow;
   end

   always @(posedge clk_slow) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] mean_of(input int s);
`ifdef LED_MEAN_ROUND_EN
      int m;
      m = (s + 64) / 128;
      return (m > 15) ? 4'hF : 4'(m);
`else
      return 4'(s / 128);
`endif
   endfunction

   // drive one cycle of input and advance the reference model
   task automatic drive(input logic s, input logic v, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      exp_t e;
      int   z;
      @(posedge clk_slow);
      #1;
      sof = s; pix_vld = v; pix_r = r; pix_g = g; pix_b = b;
      if (s) begin
         if (m_acc) err_q.push_back(cyc + 1);
         for (int i = 0; i < 8; i++) begin sr[i] = 0; sg[i] = 0; sb[i] = 0; end
         mx = 0; my = 0; m_acc = 1;
      end
      if (m_acc && v) begin
         z = mx / 2;
         sr[z] += r; sg[z] += g; sb[z] += b;
         if (mx == 15 && my == 3) begin
            e.cyc = cyc + 1;
            for (int i = 0; i < 8; i++) begin
               e.r[4*i +: 4] = mean_of(sr[i]);
               e.g[4*i +: 4] = mean_of(sg[i]);
               e.b[4*i +: 4] = mean_of(sb[i]);
            end
            last_r = e.r; last_g = e.g; last_b = e.b;
            exp_q.push_back(e);
            m_acc = 0;
         end else if (mx == 15) begin
            mx = 0; my++;
         end else begin
            mx++;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 8'h5A, 8'hA5, 8'h3C);
   endtask

   // kinds: 0 0x80, 1 zone gradient, 2 0x18, 3 0xFF, 4 0x40, 5 random
   task automatic send_frame(input int kind, input bit gap, input bit with_sof, input bit sof_on_pix,
                             input int npix, input int tail);
      logic [7:0] r, g, b;
      int         z;
      if (with_sof && !sof_on_pix) drive(1, 0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < npix; i++) begin
         z = (i % 16) / 2;
         case (kind)
            0: begin r = 8'h80; g = 8'h80; b = 8'h80; end
            1: begin r = 8'(16 * z + 5); g = r; b = r; end
            2: begin r = 8'h18; g = 8'h18; b = 8'h18; end
            3: begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
            4: begin r = 8'h40; g = 8'h40; b = 8'h40; end
            default: begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
         endcase
         drive(with_sof && sof_on_pix && i == 0, 1, r, g, b);
         if (gap) drive(0, 0, ~r, ~g, ~b);
      end
      idle(tail);
   endtask

   task automatic check_hold(input string tag);
      check({tag, "_r"}, MeanR, last_r);
      check({tag, "_g"}, MeanG, last_g);
      check({tag, "_b"}, MeanB, last_b);
   endtask

   // scoreboard: compare every output pulse against the expected queues
   always @(negedge clk_slow) begin
      if (mean_vld) begin
         if (exp_q.size() == 0) begin
            check("unexpected_mean_vld", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("vld_cycle", mon_e.cyc, cyc);
            check("vld_cycle_rev", cyc, mon_e.cyc);
            check("mean_r", MeanR, mon_e.r);
            check("mean_g", MeanG, mon_e.g);
            check("mean_b", MeanB, mon_e.b);
         end
      end
      if (frame_err) begin
         if (err_q.size() == 0) begin
            check("unexpected_frame_err", 32'd1, 32'd0);
         end else begin
            mon_c = err_q.pop_front();
            check("err_cycle", cyc, mon_c);
         end
      end
   end

   initial begin
      rst = 1; sof = 0; pix_vld = 0; pix_r = 0; pix_g = 0; pix_b = 0;
      m_acc = 0; mx = 0; my = 0;
      last_r = '0; last_g = '0; last_b = '0;
      for (int i = 0; i < 8; i++) begin sr[i] = 0; sg[i] = 0; sb[i] = 0; end
      repeat (3) @(posedge clk_slow);
      #1;
      check("rst_mean_r", MeanR, 32'h0);
      check("rst_mean_g", MeanG, 32'h0);
      check("rst_mean_b", MeanB, 32'h0);
      check("rst_vld", {31'b0, mean_vld}, 32'h0);
      check("rst_err", {31'b0, frame_err}, 32'h0);
      rst = 0;

      send_frame(0, 0, 1, 0, 64, 3);
      check("uniform_r", MeanR, 32'h8888_8888);
      send_frame(1, 0, 1, 1, 64, 3);
      check("gradient_r", MeanR, 32'h7654_3210);
      send_frame(2, 0, 1, 0, 64, 3);
`ifdef LED_MEAN_ROUND_EN
      check("x18_r", MeanR, 32'h2222_2222);
`else
      check("x18_r", MeanR, 32'h1111_1111);
`endif
      send_frame(3, 0, 1, 0, 64, 3);
      check("sat_r", MeanR, 32'hFFFF_FFFF);

      send_frame(5, 0, 1, 0, 30, 3);
      check_hold("abort_hold");
      send_frame(4, 0, 1, 0, 64, 3);
      check("abort_r", MeanR, 32'h4444_4444);

      send_frame(5, 1, 1, 1, 64, 3);
      send_frame(5, 0, 0, 0, 10, 4);
      check_hold("stray_hold");

      send_frame(2, 0, 1, 0, 64, 0);
      send_frame(5, 0, 1, 0, 64, 3);

      send_frame(5, 0, 1, 0, 20, 0);
      @(posedge clk_slow);
      #1;
      rst = 1; sof = 0; pix_vld = 0;
      m_acc = 0; last_r = '0; last_g = '0; last_b = '0;
      @(posedge clk_slow);
      #1;
      rst = 0;
      check_hold("midrst");
      check("midrst_vld", {31'b0, mean_vld}, 32'h0);
      send_frame(5, 0, 1, 0, 64, 5);

      check("sb_pending_means", exp_q.size(), 0);
      check("sb_pending_errs", err_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
